prog_loader: RTL and testbench

- Writer side of the instruction-memory interface that the CPU fetch path reads.
- Accepts a byte stream from a host link over a valid/ready handshake.
- Assembles the bytes into little-endian 32-bit instruction words and writes them to consecutive instruction-memory byte addresses.
- Holds the CPU in reset until a complete program has been written.

---
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Host-link program loader: receives a length-prefixed byte stream, writes
// little-endian 32-bit words to instruction memory, and holds the CPU in reset until done.
module prog_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter int                    MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int          IDX_W   = ADDR_WIDTH - 2;
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        CHECK,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        len;
    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         byte_cnt;
    logic [31:0]        asm_word;
    logic               xfer;
    logic               last_word;
    logic               len_bad;

    assign xfer      = byte_valid && byte_ready;
    assign last_word = (word_idx == (IDX_W'(len) - IDX_W'(1)));
    assign len_bad   = (len == 16'd0) || ({1'b0, len} > MAX_LEN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LEN_LO;
            LEN_LO:  if (xfer) state_next = LEN_HI;
            LEN_HI:  if (xfer) state_next = CHECK;
            CHECK:   state_next = len_bad ? ERR : DATA;
            DATA:    if (xfer && (byte_cnt == 2'd3)) state_next = WRITE;
            WRITE:   state_next = last_word ? DONE : DATA;
            DONE:    if (start) state_next = LEN_LO;
            ERR:     if (start) state_next = LEN_LO;
            default: state_next = IDLE;
        endcase
    end

    // Every status output is a pure function of state; done/err are "sticky"
    // simply because the FSM parks in DONE/ERR until the next start.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst    = 1'b1;
        case (state)
            LEN_LO, LEN_HI, DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            CHECK:   busy = 1'b1;
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    // The write address and data are loaded together with the 4th byte, so they
    // are valid throughout WRITE and hold afterwards while the next word assembles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            mem_addr  <= START_ADDR;
            mem_wdata <= '0;
        end else begin
            case (state)
                LEN_LO: if (xfer) len[7:0] <= byte_data;
                LEN_HI: if (xfer) len[15:8] <= byte_data;
                CHECK: begin
                    word_idx <= '0;
                    byte_cnt <= '0;
                end
                DATA: begin
                    if (xfer) begin
                        asm_word <= {byte_data, asm_word[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {byte_data, asm_word[31:8]};
                            mem_addr  <= START_ADDR + {word_idx, 2'b00};
                        end
                    end
                end
                WRITE: if (!last_word) word_idx <= word_idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of whole-load vectors plus
// hand-written sequences for reset mid-load and a start pulse during DATA.
module tb_prog_loader;

    localparam int          ADDR_WIDTH = 32;
    localparam logic [31:0] START_ADDR = 32'h0000_0000;
    localparam int          MAX_WORDS  = 1024;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .START_ADDR(START_ADDR),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [127:0] stream;
        int           nbytes;
        int           max_gap;
        int           exp_writes;
        logic [31:0]  exp_data0;
        logic [31:0]  exp_data1;
        logic         exp_done;
    } vec_t;

    vec_t        vecs[5];
    int          checks;
    int          errors;
    int          cyc;
    int          wr_cnt;
    logic [31:0] wr_addr[8];
    logic [31:0] wr_data[8];
    int          wr_cyc[8];
    int          xfer_cyc[16];
    int          done_cyc;
    logic        done_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
            check_output("ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
        if (done === 1'b1 && done_q !== 1'b1) done_cyc = cyc;
        done_q = done;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input int idx);
        bit ok;
        ok = 1'b0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int n = 0; n < 50; n++) begin
            if (byte_ready === 1'b1) begin
                tick();
                if (idx < 16) xfer_cyc[idx] = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("[TB] FAIL byte_accept_timeout: got ready=0 expected ready=1 for byte %0d", idx);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("[TB] FAIL busy_timeout: got busy=1 expected busy=0");
        end
        repeat (2) tick();
    endtask

    task automatic apply_stimulus(input int v);
        wr_cnt   = 0;
        done_cyc = -1;
        pulse_start();
        check_output("start_busy", {31'd0, busy}, 32'd1);
        check_output("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_output("start_flags", {30'd0, done, err}, 32'd0);
        for (int i = 0; i < vecs[v].nbytes; i++) begin
            send_byte(vecs[v].stream[8*i +: 8], int'($urandom_range(0, vecs[v].max_gap)), i);
        end
        byte_valid = 1'b0;
        wait_idle();
    endtask

    task automatic check_vector(input int v);
        check_output($sformatf("v%0d_writes", v), 32'(wr_cnt), 32'(vecs[v].exp_writes));
        if (vecs[v].exp_writes > 0 && wr_cnt > 0) begin
            check_output($sformatf("v%0d_addr0", v), wr_addr[0], START_ADDR);
            check_output($sformatf("v%0d_data0", v), wr_data[0], vecs[v].exp_data0);
        end
        if (vecs[v].exp_writes > 1 && wr_cnt > 1) begin
            check_output($sformatf("v%0d_addr1", v), wr_addr[1], START_ADDR + 32'd4);
            check_output($sformatf("v%0d_data1", v), wr_data[1], vecs[v].exp_data1);
        end
        check_output($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].exp_done});
        check_output($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, !vecs[v].exp_done});
        check_output($sformatf("v%0d_cpu_rst", v), {31'd0, cpu_rst}, {31'd0, !vecs[v].exp_done});
        check_output($sformatf("v%0d_idle_outs", v), {29'd0, busy, byte_ready, mem_we}, 32'd0);
        if (vecs[v].exp_done && wr_cnt > 0 && wr_cnt <= 8)
            check_output($sformatf("v%0d_done_timing", v), 32'(done_cyc), 32'(wr_cyc[wr_cnt-1] + 1));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        wr_cnt     = 0;
        done_cyc   = -1;
        done_q     = 1'b0;
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        if ({32'd0, START_ADDR} + 64'(4 * (MAX_WORDS - 1)) >= (64'd1 << ADDR_WIDTH)) begin
            $display("[TB] FAIL addr_fit: got last address beyond %0d bits expected fit", ADDR_WIDTH);
            $fatal(1, "[TB] START_ADDR + 4*(MAX_WORDS-1) does not fit");
        end

        vecs[0] = '{128'h00A0_0593_0050_0513_0002, 10, 0, 2, 32'h0050_0513, 32'h00A0_0593, 1'b1};
        vecs[1] = '{128'h00A0_0593_0050_0513_0002, 10, 3, 2, 32'h0050_0513, 32'h00A0_0593, 1'b1};
        vecs[2] = '{128'h0000,                      2,  0, 0, 32'h0,        32'h0,        1'b0};
        vecs[3] = '{128'h0401,                      2,  0, 0, 32'h0,        32'h0,        1'b0};
        vecs[4] = '{128'hDEAD_BEEF_0001,            6,  1, 1, 32'hDEAD_BEEF, 32'h0,       1'b1};

        repeat (3) tick();
        check_output("rst_ready", {31'd0, byte_ready}, 32'd0);
        check_output("rst_we", {31'd0, mem_we}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        check_output("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_output("rst_addr", mem_addr, START_ADDR);
        check_output("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            apply_stimulus(v);
            check_vector(v);
            if (v == 0 && wr_cnt >= 2) begin
                check_output("v0_we_latency0", 32'(wr_cyc[0]), 32'(xfer_cyc[5]));
                check_output("v0_we_latency1", 32'(wr_cyc[1]), 32'(xfer_cyc[9]));
                check_output("v0_throughput", 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
            end
        end

        // Start pulse in the middle of DATA must not restart the load.
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 1);
        send_byte(8'hAA, 0, 2);
        send_byte(8'hBB, 0, 3);
        byte_valid = 1'b0;
        pulse_start();
        send_byte(8'hCC, 0, 4);
        send_byte(8'hDD, 0, 5);
        byte_valid = 1'b0;
        wait_idle();
        check_output("ign_start_writes", 32'(wr_cnt), 32'd1);
        check_output("ign_start_data", wr_data[0], 32'hDDCC_BBAA);
        check_output("ign_start_done", {31'd0, done}, 32'd1);

        // Reset one cycle after the 2nd byte of word 1 in a 3-word load.
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h03, 0, 0);
        send_byte(8'h00, 0, 1);
        send_byte(8'h11, 0, 2);
        send_byte(8'h22, 0, 3);
        send_byte(8'h33, 0, 4);
        send_byte(8'h44, 0, 5);
        send_byte(8'h55, 0, 6);
        send_byte(8'h66, 0, 7);
        byte_data = 8'h77;
        tick();
        rst = 1'b0;
        tick();
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        check_output("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_output("midrst_done", {31'd0, done}, 32'd0);
        check_output("midrst_ready", {31'd0, byte_ready}, 32'd0);
        check_output("midrst_addr", mem_addr, START_ADDR);
        rst = 1'b1;
        repeat (10) tick();
        byte_valid = 1'b0;
        check_output("midrst_writes", 32'(wr_cnt), 32'd1);
        check_output("midrst_word0", wr_data[0], 32'h4433_2211);
        check_output("midrst_idle_busy", {31'd0, busy}, 32'd0);

        apply_stimulus(4);
        check_vector(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
